// File: rtl/sfx_stream_player_if.sv
// ROM read port plus the left/right Avalon-ST sample streams of sfx_stream_player.
// master = sequencer side, slave = ROM/codec side.
interface sfx_stream_player_if;
    logic        rom_rd;
    logic        rom_sel;
    logic [14:0] rom_addr;
    logic [15:0] rom_data;
    logic [15:0] L_DATA;
    logic [15:0] R_DATA;
    logic        L_VALID;
    logic        R_VALID;
    logic        L_READY;
    logic        R_READY;

    modport master (
        output rom_rd, rom_sel, rom_addr,
        input  rom_data,
        output L_DATA, R_DATA, L_VALID, R_VALID,
        input  L_READY, R_READY
    );

    modport slave (
        input  rom_rd, rom_sel, rom_addr,
        output rom_data,
        input  L_DATA, R_DATA, L_VALID, R_VALID,
        output L_READY, R_READY
    );
endinterface

// File: rtl/sfx_stream_player.sv
// Sound-effect sequencer: priority-arbitrated triggers, tick-paced ROM reads, sample FIFO, dual-sink stream.
// Optional SFX_ATTEN_EN adds a 2-bit arithmetic-shift attenuation of ROM samples.
module sfx_stream_player #(
    parameter int SAMPLE_PERIOD = 1042,
    parameter int PELLET_LEN    = 17555,
    parameter int GAMEOVER_LEN  = 16533,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pellet_trig,
    input  logic                       gameover_trig,
    input  logic                       stop,
`ifdef SFX_ATTEN_EN
    input  logic [1:0]                 atten,
`endif
    sfx_stream_player_if.master        bus,
    output logic [1:0]                 active_sfx,
    output logic                       overflow
);
    localparam int CW = $clog2(SAMPLE_PERIOD);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        PELLET   = 2'b01,
        GAMEOVER = 2'b10
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic [14:0]   index, index_next, last_index;
    logic          rd_pending;
    logic [15:0]   rom_sample;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, push, pop, accept;
    logic [15:0]   push_data;
    logic          l_sent, r_sent, l_done, r_done;

    assign tick       = (tick_cnt == CW'(SAMPLE_PERIOD - 1));
    assign last_index = (state == GAMEOVER) ? 15'(GAMEOVER_LEN - 1) : 15'(PELLET_LEN - 1);

    always_ff @(posedge clk) begin
        if (!reset || tick) tick_cnt <= '0;
        else                tick_cnt <= tick_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            index      <= '0;
            rd_pending <= 1'b0;
        end else begin
            state      <= state_next;
            index      <= index_next;
            rd_pending <= bus.rom_rd & ~stop;
        end
    end

    always_comb begin
        state_next = state;
        index_next = index;
        if (stop) begin
            state_next = IDLE;
            index_next = '0;
        end else if (gameover_trig) begin
            state_next = GAMEOVER;
            index_next = '0;
        end else if (pellet_trig && state != GAMEOVER) begin
            state_next = PELLET;
            index_next = '0;
        end else if (tick && state != IDLE) begin
            if (index == last_index) begin
                state_next = IDLE;
                index_next = '0;
            end else begin
                index_next = index + 1'b1;
            end
        end
    end

    always_comb begin
        active_sfx   = state;
        bus.rom_rd   = tick && (state != IDLE);
        bus.rom_sel  = (state == GAMEOVER);
        bus.rom_addr = index;
    end

`ifdef SFX_ATTEN_EN
    assign rom_sample = 16'($signed(bus.rom_data) >>> atten);
`else
    assign rom_sample = bus.rom_data;
`endif

    // Idle ticks inject silence so the codec never starves.
    assign push      = rd_pending || (tick && state == IDLE);
    assign push_data = rd_pending ? rom_sample : 16'h0000;
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign l_done    = l_sent || (bus.L_VALID && bus.L_READY);
    assign r_done    = r_sent || (bus.R_VALID && bus.R_READY);
    assign pop       = !empty && l_done && r_done;
    assign accept    = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (!reset || stop) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            l_sent   <= 1'b0;
            r_sent   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                l_sent <= 1'b0;
                r_sent <= 1'b0;
            end else begin
                l_sent <= l_done;
                r_sent <= r_done;
            end
            if (push && !accept) overflow <= 1'b1;
        end
    end

    // NOTE: sample storage is deliberately not reset; the empty gate below keeps stale words off the outputs.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign bus.L_DATA  = empty ? 16'h0000 : mem[rd_ptr[AW-1:0]];
    assign bus.R_DATA  = bus.L_DATA;
    assign bus.L_VALID = !empty && !l_sent;
    assign bus.R_VALID = !empty && !r_sent;
endmodule

// File: tb/tb_sfx_stream_player.sv
// Self-checking bench for sfx_stream_player: stimulus table, directed corner sequences and a
// randomized run, all checked against a queue-based behavioural model. Short ROMs/period keep runtime small.
module tb_sfx_stream_player;
    localparam int SP = 16;
    localparam int PL = 20;
    localparam int GL = 12;
    localparam int FD = 8;

    logic       clk;
    logic       reset, pellet_trig, gameover_trig, stop;
    logic [1:0] active_sfx;
    logic       overflow;
`ifdef SFX_ATTEN_EN
    logic [1:0] atten;
`endif

    sfx_stream_player_if bus();

    sfx_stream_player #(
        .SAMPLE_PERIOD(SP), .PELLET_LEN(PL), .GAMEOVER_LEN(GL), .FIFO_DEPTH(FD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pellet_trig  (pellet_trig),
        .gameover_trig(gameover_trig),
        .stop         (stop),
`ifdef SFX_ATTEN_EN
        .atten        (atten),
`endif
        .bus          (bus),
        .active_sfx   (active_sfx),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    bit check_en = 0;

    // Behavioural model: states as plain ints (0 idle, 1 pellet, 2 game over), FIFO as a queue.
    int          m_cnt, m_st, m_idx;
    bit          m_pend, m_ls, m_rs, m_ovf;
    logic [15:0] m_pdata;
    logic [15:0] m_q[$];

    // Observations of the last cycle, taken at the falling edge.
    bit          obs_rd, obs_sel, obs_ltx, obs_lv, obs_rv;
    logic [14:0] obs_addr;
    logic [15:0] obs_ldata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] rom_fn(input bit sel, input logic [14:0] addr);
        return sel ? (16'h8000 | 16'(addr)) : 16'(addr) + 16'd1;
    endfunction

    function automatic logic [53:0] model_outputs();
        bit          rd;
        logic [15:0] head;
        rd   = (m_cnt == SP - 1) && (m_st != 0);
        head = (m_q.size() > 0) ? m_q[0] : 16'h0000;
        return {rd, rd && (m_st == 2), rd ? 15'(m_idx) : 15'h0, head, head,
                (m_q.size() > 0) && !m_ls, (m_q.size() > 0) && !m_rs, 2'(m_st), m_ovf};
    endfunction

    function automatic void model_step(input bit rst_b, pt, gt, sp, lr, rr);
        bit          tick, rd, ltx, rtx, pop, push;
        logic [15:0] pdata;
        int          len;
        if (!rst_b) begin
            m_cnt = 0; m_st = 0; m_idx = 0; m_pend = 0; m_pdata = '0;
            m_ls = 0; m_rs = 0; m_ovf = 0; m_q.delete();
            return;
        end
        tick  = (m_cnt == SP - 1);
        rd    = tick && (m_st != 0);
        ltx   = (m_q.size() > 0) && !m_ls && lr;
        rtx   = (m_q.size() > 0) && !m_rs && rr;
        pop   = (m_q.size() > 0) && (m_ls || ltx) && (m_rs || rtx);
        push  = m_pend || (tick && m_st == 0);
        pdata = m_pend ? m_pdata : 16'h0000;
        m_cnt = (m_cnt + 1) % SP;
        if (sp) begin
            m_q.delete(); m_ls = 0; m_rs = 0; m_ovf = 0;
            m_st = 0; m_idx = 0; m_pend = 0;
            return;
        end
        if (pop) begin
            void'(m_q.pop_front());
            m_ls = 0; m_rs = 0;
        end else begin
            m_ls = m_ls | ltx;
            m_rs = m_rs | rtx;
        end
        if (push) begin
            if (m_q.size() < FD) m_q.push_back(pdata);
            else                 m_ovf = 1;
        end
        m_pend  = rd;
        m_pdata = rom_fn(m_st == 2, 15'(m_idx));
        len     = (m_st == 2) ? GL : PL;
        if (gt) begin
            m_st = 2; m_idx = 0;
        end else if (pt && m_st != 2) begin
            m_st = 1; m_idx = 0;
        end else if (rd) begin
            if (m_idx == len - 1) begin m_st = 0; m_idx = 0; end
            else m_idx++;
        end
    endfunction

    function automatic logic [53:0] raw_outputs();
        return {bus.rom_rd, bus.rom_sel, bus.rom_addr, bus.L_DATA, bus.R_DATA,
                bus.L_VALID, bus.R_VALID, active_sfx, overflow};
    endfunction

    task automatic run_cycle(input bit rst_b, pt, gt, sp, lr, rr);
        logic [53:0] act_o;
        reset = rst_b; pellet_trig = pt; gameover_trig = gt; stop = sp;
        bus.L_READY = lr; bus.R_READY = rr;
        @(negedge clk);
        act_o = {bus.rom_rd, bus.rom_rd & bus.rom_sel, bus.rom_rd ? bus.rom_addr : 15'h0,
                 bus.L_DATA, bus.R_DATA, bus.L_VALID, bus.R_VALID, active_sfx, overflow};
        if (check_en) check("outputs", act_o, model_outputs());
        obs_rd    = bus.rom_rd;
        obs_sel   = bus.rom_sel;
        obs_addr  = bus.rom_addr;
        obs_lv    = bus.L_VALID;
        obs_rv    = bus.R_VALID;
        obs_ltx   = bus.L_VALID && bus.L_READY;
        obs_ldata = bus.L_DATA;
        model_step(rst_b, pt, gt, sp, lr, rr);
        @(posedge clk);
        #1;
        cyc++;
        bus.rom_data = obs_rd ? rom_fn(obs_sel, obs_addr) : 16'($urandom);
    endtask

    task automatic wait_rd(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            run_cycle(1, 0, 0, 0, 1, 1);
            if (obs_rd) ok = 1;
        end
    endtask

    typedef struct {
        bit         pt, gt, sp, lr, rr;
        int         cycles;
        logic [1:0] exp_active;
        bit         exp_ovf;
    } vec_t;

    vec_t        vecs[13];
    logic [15:0] got[$];
    bit          ok;
    int          n_rd, n_sel0, pct, r;

    initial begin
        reset = 0; pellet_trig = 0; gameover_trig = 0; stop = 0;
        bus.rom_data = '0; bus.L_READY = 1; bus.R_READY = 1;
`ifdef SFX_ATTEN_EN
        atten = 2'b00;
`endif
        model_step(0, 0, 0, 0, 1, 1);
        repeat (3) run_cycle(0, 0, 0, 0, 1, 1);
        check_en = 1;
        check("reset_state", raw_outputs(), 54'h0);

        //            pt gt sp lr rr cycles active ovf
        vecs[0]  = '{0, 0, 0, 1, 1,  40, 2'b00, 0};
        vecs[1]  = '{1, 0, 0, 1, 1,   5, 2'b01, 0};
        vecs[2]  = '{0, 1, 0, 1, 1,   5, 2'b10, 0};
        vecs[3]  = '{1, 0, 0, 1, 1,   5, 2'b10, 0};
        vecs[4]  = '{0, 0, 1, 1, 1,   3, 2'b00, 0};
        vecs[5]  = '{1, 0, 1, 1, 1,   3, 2'b00, 0};
        vecs[6]  = '{0, 0, 0, 1, 0, 200, 2'b00, 1};
        vecs[7]  = '{0, 0, 0, 1, 1,  20, 2'b00, 1};
        vecs[8]  = '{0, 0, 1, 1, 1,   2, 2'b00, 0};
        vecs[9]  = '{1, 0, 0, 1, 1, 360, 2'b00, 0};
        vecs[10] = '{0, 1, 0, 1, 1, 100, 2'b10, 0};
        vecs[11] = '{0, 1, 0, 1, 1, 150, 2'b10, 0};
        vecs[12] = '{0, 0, 0, 1, 1, 100, 2'b00, 0};
        for (int i = 0; i < 13; i++) begin
            run_cycle(1, vecs[i].pt, vecs[i].gt, vecs[i].sp, vecs[i].lr, vecs[i].rr);
            for (int k = 1; k < vecs[i].cycles; k++) run_cycle(1, 0, 0, 0, vecs[i].lr, vecs[i].rr);
            check($sformatf("vec%0d_active", i), active_sfx, vecs[i].exp_active);
            check($sformatf("vec%0d_overflow", i), overflow, vecs[i].exp_ovf);
        end

        // Full pellet playback: samples 1..PL in order, PL reads all from the pellet ROM.
        run_cycle(1, 0, 0, 1, 1, 1);
        run_cycle(1, 1, 0, 0, 1, 1);
        n_rd = 0; n_sel0 = 0; got.delete();
        repeat (PL * SP + 60) begin
            run_cycle(1, 0, 0, 0, 1, 1);
            if (obs_rd) begin
                n_rd++;
                if (!obs_sel) n_sel0++;
            end
            if (obs_ltx && obs_ldata != 16'h0000) got.push_back(obs_ldata);
        end
        check("pellet_reads", n_rd, PL);
        check("pellet_sel0", n_sel0, PL);
        check("pellet_count", got.size(), PL);
        for (int i = 0; i < PL && i < got.size(); i++) check($sformatf("pellet_sample%0d", i), got[i], i + 1);
        check("pellet_back_idle", active_sfx, 2'b00);

        // Game-over pre-empts pellet; a pellet trigger during game-over is ignored.
        run_cycle(1, 0, 0, 1, 1, 1);
        run_cycle(1, 1, 0, 0, 1, 1);
        ok = 0;
        for (int i = 0; i < 10 * SP && !ok; i++) begin
            run_cycle(1, 0, 0, 0, 1, 1);
            if (obs_rd && obs_addr == 15'd5) ok = 1;
        end
        check("preempt_reach_idx5", ok, 1);
        run_cycle(1, 0, 1, 0, 1, 1);
        wait_rd(2 * SP, ok);
        check("preempt_rd_seen", ok, 1);
        check("preempt_sel_addr", {obs_sel, obs_addr}, {1'b1, 15'd0});
        run_cycle(1, 1, 0, 0, 1, 1);
        wait_rd(2 * SP, ok);
        check("ignore_pellet_rd_seen", ok, 1);
        check("ignore_pellet_sel_addr", {obs_sel, obs_addr}, {1'b1, 15'd1});

        // Left accepts, right stalls: left holds off, FIFO fills and overflows, right release pops.
        run_cycle(1, 0, 0, 1, 1, 0);
        ok = 0;
        for (int i = 0; i < 2 * SP && !ok; i++) begin
            run_cycle(1, 0, 0, 0, 1, 0);
            if (obs_ltx) ok = 1;
        end
        check("split_l_took", ok, 1);
        run_cycle(1, 0, 0, 0, 1, 0);
        check("split_lv_dropped", {obs_lv, obs_rv}, 2'b01);
        repeat (10 * SP) run_cycle(1, 0, 0, 0, 1, 0);
        check("split_overflow", overflow, 1);
        check("split_lv_still_low", bus.L_VALID, 0);
        run_cycle(1, 0, 0, 0, 0, 1);
        check("split_r_took", obs_rv, 1);
        run_cycle(1, 0, 0, 0, 0, 0);
        check("split_lv_reasserts", obs_lv, 1);

        // Reset in the middle of game-over clears everything; a new trigger reads from index 0.
        run_cycle(1, 0, 0, 1, 1, 1);
        run_cycle(1, 0, 1, 0, 1, 1);
        ok = 0;
        for (int i = 0; i < 5 * SP && !ok; i++) begin
            run_cycle(1, 0, 0, 0, 1, 1);
            if (obs_rd && obs_addr == 15'd2) ok = 1;
        end
        check("midreset_reach_idx2", ok, 1);
        run_cycle(0, 0, 0, 0, 1, 1);
        check("midreset_outputs_zero", raw_outputs(), 54'h0);
        run_cycle(1, 0, 1, 0, 1, 1);
        wait_rd(2 * SP, ok);
        check("midreset_rd_seen", ok, 1);
        check("midreset_sel_addr", {obs_sel, obs_addr}, {1'b1, 15'd0});

        // Randomized traffic with phases of scarce, moderate and plentiful sink readiness.
        pct = 95;
        for (int i = 0; i < 2500; i++) begin
            if (i % 250 == 0) begin
                r = int'($urandom_range(0, 2));
                pct = (r == 0) ? 3 : (r == 1) ? 50 : 95;
            end
            run_cycle(1, ($urandom % 150) == 0, ($urandom % 400) == 0, ($urandom % 350) == 0,
                      ($urandom % 100) < pct, ($urandom % 100) < pct);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
